// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
// Digits are held as 4-bit BCD values.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEC_MAX = 59;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min1;
    bcd_t min0;
    bcd_t sec1;
    bcd_t sec0;
  } time_t;

  function automatic logic bcd_is_zero(bcd_t d);
    return d == '0;
  endfunction

endpackage

// File: rtl/stopwatch_core_counter.sv
// Two-digit BCD field counter, wrapping 00..MAX in both directions.
// bcd_field_counter: used for both the seconds and the minutes field.
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output bcd_t tens,
  output bcd_t units,
  output logic at_max,
  output logic at_zero
);

  localparam bcd_t MT = bcd_t'(MAX / 10);
  localparam bcd_t MU = bcd_t'(MAX % 10);

  assign at_max  = (tens == MT) && (units == MU);
  assign at_zero = bcd_is_zero(tens) && bcd_is_zero(units);

  always_ff @(posedge clk) begin
    if (reset) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= '0;
      end else begin
        units <= units + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens  <= MT;
        units <= MU;
      end else if (bcd_is_zero(units)) begin
        tens  <= tens - 4'd1;
        units <= 4'd9;
      end else begin
        units <= units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with up/down count, adjust, pause and wrap/expiry.
// Optional lap hold display is enabled with `define LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 59,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  input  logic               adj_tick,
  input  logic               pause,
  input  logic               adjust,
  input  logic               select,
  input  logic               dir,
  output logic [DIGIT_W-1:0] min1,
  output logic [DIGIT_W-1:0] min0,
  output logic [DIGIT_W-1:0] sec1,
  output logic [DIGIT_W-1:0] sec0,
  output logic               paused,
  output logic               wrap,
  output logic               expired
`ifdef LAP_EN
  ,
  input  logic               lap
`endif
);

  logic  pause_q;
  logic  s_max, s_zero, m_max, m_zero;
  logic  run, up, down, adj_s, adj_m;
  logic  wrap_d, exp_d, rise;
  time_t live, shown;

  assign rise  = pause & ~pause_q;
  assign run   = ~adjust & ~paused & tick_en;
  assign up    = run & ~dir;
  // a running down-count parked at 00:00 simply holds
  assign down  = run & dir & ~(s_zero & m_zero);
  assign adj_s = adjust & adj_tick & select;
  assign adj_m = adjust & adj_tick & ~select;

  assign wrap_d = up & s_max & m_max;
  assign exp_d  = down & m_zero & bcd_is_zero(live.sec1)
                & (live.sec0 == 4'd1);

  bcd_field_counter #(.MAX(SEC_MAX)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .inc     (up | adj_s),
    .dec     (down),
    .tens    (live.sec1),
    .units   (live.sec0),
    .at_max  (s_max),
    .at_zero (s_zero)
  );

  bcd_field_counter #(.MAX(MIN_MAX)) u_min (
    .clk     (clk),
    .reset   (reset),
    .inc     ((up & s_max) | adj_m),
    .dec     (down & s_zero),
    .tens    (live.min1),
    .units   (live.min0),
    .at_max  (m_max),
    .at_zero (m_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_q <= 1'b0;
      paused  <= 1'b0;
      wrap    <= 1'b0;
      expired <= 1'b0;
    end else begin
      pause_q <= pause;
      paused  <= rise ? ~paused : (paused | exp_d);
      wrap    <= wrap_d;
      expired <= exp_d;
    end
  end

`ifdef LAP_EN
  logic  lap_q;
  time_t cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= 1'b0;
      cap   <= '0;
    end else begin
      lap_q <= lap;
      if (lap & ~lap_q) cap <= live;
    end
  end

  assign shown = lap_q ? cap : live;
`else
  assign shown = live;
`endif

  assign min1 = shown.min1;
  assign min0 = shown.min0;
  assign sec1 = shown.sec1;
  assign sec0 = shown.sec0;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomised and directed bench for stopwatch_core (MIN_MAX 59 and 20).
// Reference model works on integer minutes/seconds.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_en = 1'b0, adj_tick = 1'b0, pause = 1'b0;
  logic adjust = 1'b0, select = 1'b0, dir = 1'b0;
  logic [3:0] a_m1, a_m0, a_s1, a_s0, b_m1, b_m0, b_s1, b_s0;
  logic a_p, a_w, a_e, b_p, b_w, b_e;

  int checks = 0;
  int errors = 0;

  int mm[2], ss[2];
  bit pd[2], pq[2], wr[2], ex[2];
  int mmax[2] = '{59, 20};

  always #5 clk = ~clk;

  stopwatch_core #(.MIN_MAX(59)) u_dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .adj_tick(adj_tick),
    .pause(pause), .adjust(adjust), .select(select), .dir(dir),
    .min1(a_m1), .min0(a_m0), .sec1(a_s1), .sec0(a_s0),
    .paused(a_p), .wrap(a_w), .expired(a_e)
`ifdef LAP_EN
    , .lap(1'b0)
`endif
  );

  stopwatch_core #(.MIN_MAX(20)) u_d20 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .adj_tick(adj_tick),
    .pause(pause), .adjust(adjust), .select(select), .dir(dir),
    .min1(b_m1), .min0(b_m0), .sec1(b_s1), .sec0(b_s0),
    .paused(b_p), .wrap(b_w), .expired(b_e)
`ifdef LAP_EN
    , .lap(1'b0)
`endif
  );

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_d(int i);
    return ((mm[i] / 10) << 12) | ((mm[i] % 10) << 8)
         | ((ss[i] / 10) << 4) | (ss[i] % 10);
  endfunction

  task automatic model(int i);
    int  t;
    bit  rise, oldp;
    wr[i] = 0;
    ex[i] = 0;
    if (reset) begin
      mm[i] = 0; ss[i] = 0; pd[i] = 0; pq[i] = 0;
      return;
    end
    rise = pause && !pq[i];
    oldp = pd[i];
    t = mm[i] * 60 + ss[i];
    if (adjust) begin
      if (adj_tick) begin
        if (select) ss[i] = (ss[i] + 1) % 60;
        else        mm[i] = (mm[i] + 1) % (mmax[i] + 1);
      end
    end else if (tick_en && !oldp) begin
      if (!dir) begin
        if (t == mmax[i] * 60 + 59) begin
          t = 0;
          wr[i] = 1;
        end else t = t + 1;
        mm[i] = t / 60; ss[i] = t % 60;
      end else if (t > 0) begin
        t = t - 1;
        if (t == 0) ex[i] = 1;
        mm[i] = t / 60; ss[i] = t % 60;
      end
    end
    pd[i] = rise ? !oldp : (oldp | ex[i]);
    pq[i] = pause;
  endtask

  function automatic int dig_a();
    return {16'd0, a_m1, a_m0, a_s1, a_s0};
  endfunction

  function automatic int dig_b();
    return {16'd0, b_m1, b_m0, b_s1, b_s0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check("digits59", dig_a(), exp_d(0));
    check("paused59", a_p, pd[0]);
    check("wrap59", a_w, wr[0]);
    check("expired59", a_e, ex[0]);
    check("digits20", dig_b(), exp_d(1));
    check("paused20", b_p, pd[1]);
    check("wrap20", b_w, wr[1]);
    check("expired20", b_e, ex[1]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic ticks(int n);
    tick_en = 1'b1;
    repeat (n) cyc();
    tick_en = 1'b0;
  endtask

  task automatic adj(bit sel, int n);
    adjust = 1'b1;
    select = sel;
    adj_tick = 1'b1;
    repeat (n) cyc();
    adj_tick = 1'b0;
    adjust = 1'b0;
  endtask

  int nw, ne;

  initial begin
    cyc();
    do_reset();
    check("reset_digits", dig_a(), 0);
    check("reset_paused", a_p, 0);

    // 1: 61 up ticks -> 01:01, no wrap
    nw = 0;
    tick_en = 1'b1;
    repeat (61) begin cyc(); nw += a_w; end
    tick_en = 1'b0;
    check("t1_digits", dig_a(), 16'h0101);
    check("t1_nowrap", nw, 0);

    // 2: 59:58 + 2 ticks -> 00:00 with one wrap pulse
    do_reset();
    adj(1'b0, 59);
    adj(1'b1, 58);
    check("t2_preset", dig_a(), 16'h5958);
    ticks(1);
    check("t2_nowrap", a_w, 0);
    ticks(1);
    check("t2_wrap", a_w, 1);
    check("t2_digits", dig_a(), 0);
    cyc();
    check("t2_wrap_once", a_w, 0);

    // 3: down from 01:00
    do_reset();
    dir = 1'b1;
    adj(1'b0, 1);
    ne = 0;
    tick_en = 1'b1;
    repeat (60) begin cyc(); ne += a_e; end
    tick_en = 1'b0;
    check("t3_digits", dig_a(), 0);
    check("t3_expired_once", ne, 1);
    check("t3_paused", a_p, 1);
    ticks(3);
    check("t3_hold", dig_a(), 0);
    pause = 1'b1; cyc(); pause = 1'b0;
    check("t3_resumed", a_p, 0);
    ne = 0;
    tick_en = 1'b1;
    repeat (3) begin cyc(); ne += a_e; end
    tick_en = 1'b0;
    check("t3_run_hold", dig_a(), 0);
    check("t3_no_reexpire", ne, 0);
    dir = 1'b0;

    // 4: pause edge coincident with tick
    do_reset();
    ticks(5);
    pause = 1'b1; tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    check("t4_digits", dig_a(), 16'h0006);
    check("t4_paused", a_p, 1);
    pause = 1'b0;
    ticks(3);
    check("t4_frozen", dig_a(), 16'h0006);
    pause = 1'b1; cyc(); pause = 1'b0;
    ticks(1);
    check("t4_resumed", dig_a(), 16'h0007);

    // 5: adjust wraps without carry; tick_en ignored
    do_reset();
    tick_en = 1'b1;
    adj(1'b1, 59);
    check("t5_sec59", dig_a(), 16'h0059);
    adj(1'b1, 1);
    check("t5_sec_wrap", dig_a(), 16'h0000);
    adj(1'b0, 20);
    check("t5_min20", dig_b(), 16'h2000);
    adj(1'b0, 1);
    check("t5_min_wrap", dig_b(), 16'h0000);
    check("t5_min59side", dig_a(), 16'h2100);
    tick_en = 1'b0;

    // 6: reset beats tick at 12:34
    do_reset();
    adj(1'b0, 12);
    adj(1'b1, 34);
    check("t6_preset", dig_a(), 16'h1234);
    tick_en = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0; tick_en = 1'b0;
    check("t6_digits", dig_a(), 0);
    check("t6_paused", a_p, 0);
    check("t6_wrap", a_w, 0);
    check("t6_expired", a_e, 0);

    // random soak
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      tick_en  = ($urandom_range(0, 3) != 0);
      adj_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) adjust = ~adjust;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      select = $urandom_range(0, 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
